// File: rtl/mul32_seq_ctrl.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier controller.
// Drives an external shared wrap-around adder, one add per cycle, with valid/ready on both sides.
module mul32_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [XLEN-1:0]     op_a,
  input  logic [XLEN-1:0]     op_b,
  output logic                in_ready,
  input  logic                abort,
  output logic                busy,
  output logic [XLEN-1:0]     add_a,
  output logic [XLEN-1:0]     add_b,
  input  logic [XLEN-1:0]     add_s,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*XLEN-1:0]   product
);

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("mul32_seq_ctrl: only XLEN=32 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] m;
  logic [XLEN-1:0] p_hi;
  logic [XLEN-1:0] p_lo;
  logic [5:0]      cnt;
  logic            carry;

  // The adder has no carry-out; a wrapped sum is smaller than either operand.
  assign carry   = (add_s < add_a);
  assign product = {p_hi, p_lo};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block is defaulted first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    add_a     = '0;
    add_b     = '0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (start) state_n = S_BUSY;
      end
      S_BUSY: begin
        busy  = 1'b1;
        add_a = p_hi;
        add_b = p_lo[0] ? m : '0;
        if (abort)             state_n = S_IDLE;
        else if (cnt == 6'd31) state_n = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath; contents are don't-care after an abort, so BUSY updates unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      m    <= '0;
      p_hi <= '0;
      p_lo <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m    <= op_a;
            p_lo <= op_b;
            p_hi <= '0;
            cnt  <= '0;
          end
        end
        S_BUSY: begin
          p_hi <= {carry, add_s[XLEN-1:1]};
          p_lo <= {add_s[0], p_lo[XLEN-1:1]};
          cnt  <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed and random checks for mul32_seq_ctrl with a behavioural shared adder.
// Cycle 0 is the cycle in which start is accepted; sampling happens 1 time unit after each edge.
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        in_ready;
  logic        abort;
  logic        busy;
  logic [31:0] add_a, add_b, add_s;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign add_s = add_a + add_b;

  mul32_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .in_ready  (in_ready),
    .abort     (abort),
    .busy      (busy),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; ends in cycle 34, back in IDLE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int cyc;
    op_a = a; op_b = b; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd33);
    check({tag, "_product"}, product, exp);
    tick();
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int cyc;
    int nvalid;
    int first_valid;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_product",   product,            64'd0);
    check("rst_add_a",     {32'd0, add_a},     64'd0);
    check("rst_add_b",     {32'd0, add_b},     64'd0);

    // 3 x 5 with explicit cycle-1 handshake checks
    op_a = 32'd3; op_b = 32'd5; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t1_in_ready_c1", {63'd0, in_ready}, 64'd0);
    check("t1_busy_c1",     {63'd0, busy},     64'd1);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("t1_latency", 64'(cyc), 64'd33);
    check("t1_product", product, 64'h0000_0000_0000_000F);
    tick();
    check("t1_idle_c34", {63'd0, in_ready}, 64'd1);

    run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("zero_a", 32'h0000_0000, 32'hFFFF_FFFF, 64'h0);
    run_op("zero_b", 32'h1234_5678, 32'h0000_0000, 64'h0);

    // Backpressure: out_ready low for 10 cycles of DONE
    op_a = 32'h8000_0000; op_b = 32'h0000_0002; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("bp_latency", 64'(cyc), 64'd33);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp_product_%0d", i), product, 64'h0000_0001_0000_0000);
      tick();
    end
    out_ready = 1'b1;
    check("bp_still_valid", {63'd0, out_valid}, 64'd1);
    tick();
    check("bp_idle", {63'd0, in_ready}, 64'd1);
    check("bp_valid_drop", {63'd0, out_valid}, 64'd0);

    // start pulses in cycles 5 and 20 must be ignored
    op_a = 32'd7; op_b = 32'd9; start = 1'b1; out_ready = 1'b1;
    tick();
    op_a = 32'h0000_00AA; op_b = 32'h0000_00BB;
    nvalid = 0; first_valid = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 20);
      if (c == 5) check("sp_in_ready_c5", {63'd0, in_ready}, 64'd0);
      if (out_valid) begin
        nvalid++;
        if (first_valid == 0) first_valid = c;
        check("sp_product", product, 64'h3F);
      end
      tick();
    end
    start = 1'b0;
    check("sp_first_valid", 64'(first_valid), 64'd33);
    check("sp_valid_windows", 64'(nvalid), 64'd1);

    // abort in cycle 10, then an immediate 2 x 2
    op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_in_ready_c11",  {63'd0, in_ready},  64'd1);
    check("ab_busy_c11",      {63'd0, busy},      64'd0);
    check("ab_out_valid_c11", {63'd0, out_valid}, 64'd0);
    run_op("ab_two", 32'd2, 32'd2, 64'd4);

    // abort together with out_ready in DONE: back to IDLE, nothing delivered
    op_a = 32'd6; op_b = 32'd7; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("abd_latency", 64'(cyc), 64'd33);
    check("abd_product", product, 64'd42);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    check("abd_idle",      {63'd0, in_ready},  64'd1);
    check("abd_out_valid", {63'd0, out_valid}, 64'd0);

    // rst in cycle 15 of an operation
    op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready",  {63'd0, in_ready},  64'd1);
    check("mr_busy",      {63'd0, busy},      64'd0);
    check("mr_out_valid", {63'd0, out_valid}, 64'd0);
    check("mr_product",   product,            64'd0);
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) nvalid++;
      tick();
    end
    check("mr_no_valid", 64'(nvalid), 64'd0);

    // Random regression against a 64-bit reference multiply
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("rnd%0d", i), ra, rb, {32'd0, ra} * {32'd0, rb});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul32_seq_ctrl.md
Name: mul32_seq_ctrl

Overview:
- Multi-cycle unsigned 32x32->64 shift-add multiplier controller.
- Holds no adder of its own. It sequences the shared 32-bit combinational wrap-around adder (s = a+b mod 2^32, no carry in or out) through the add_a/add_b/add_s ports, one add per cycle.
- Sits beside the ALU as the multi-cycle MUL/MULHU unit. It uses a valid/ready handshake on input and output.

Parameters:
- XLEN, 32, operand width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request valid; accepted when start & in_ready.
- op_a  in  32  multiplicand; sampled on accept.
- op_b  in  32  multiplier; sampled on accept.
- in_ready  out  1  high only in IDLE.
- abort  in  1  cancel current operation.
- busy  out  1  high in BUSY.
- add_a  out  32  shared adder operand A.
- add_b  out  32  shared adder operand B.
- add_s  in  32  shared adder sum (combinational from add_a/add_b).
- out_valid  out  1  product valid; high only in DONE.
- out_ready  in  1  consumer accepts product.
- product  out  64  unsigned product {hi, lo}.

Behaviour:
- Registers:
  - M[31:0] holds the multiplicand.
  - P_hi[31:0] and P_lo[31:0] form the product/multiplier shift register.
  - cnt[5:0] is the iteration counter.
  - state is one of IDLE, BUSY, DONE.
- Reset, when rst is high at a clock edge:
  - state=IDLE; M, P_hi, P_lo and cnt all 0.
  - After that edge: in_ready=1, busy=0, out_valid=0, product=0, add_a=add_b=0.
  - rst has priority over start, abort and out_ready, including mid-operation. A reset during BUSY discards the work; no out_valid follows.
- IDLE:
  - add_a=0, add_b=0.
  - On start, load M=op_a, P_lo=op_b, P_hi=0, cnt=0, and go to BUSY.
  - abort and out_ready are ignored.
- BUSY, one iteration per cycle:
  - add_a=P_hi.
  - add_b = P_lo[0] ? M : 0.
  - c = (add_s < add_a), unsigned compare. This recovers the carry-out of the shared adder. c=0 whenever add_b=0.
  - Next P_hi = {c, add_s[31:1]}.
  - Next P_lo = {add_s[0], P_lo[31:1]}.
  - cnt increments each cycle.
  - When cnt==31 (the 32nd iteration), go to DONE.
  - start is ignored (in_ready=0).
- DONE:
  - out_valid=1; product={P_hi, P_lo}, held stable.
  - add_a=add_b=0.
  - out_ready moves to IDLE on the next edge. Without it, DONE is held indefinitely (backpressure).
  - start is ignored.
- abort:
  - In BUSY or DONE, go to IDLE on the next edge.
  - out_valid drops; product keeps its last register value but is don't-care.
  - If abort and out_ready are both high in DONE, the result is IDLE either way; the bench must not count it as a delivered product.
- Timing:
  - The request is accepted in cycle 0.
  - busy is high in cycles 1..32.
  - out_valid is first high in cycle 33.
  - With out_ready tied high, the next request can be accepted in cycle 34. Minimum initiation interval is 34 cycles.
- product is meaningful only while out_valid=1. The same holds for its registers mid-computation.
- Arithmetic:
  - Result is exact unsigned 64-bit; no overflow is possible.
  - The carry into P_hi[31] is always captured.
  - Operands of 0 still take the full 32 iterations; there is no early exit.

Test Plan:
- Reset, then start with op_a=3, op_b=5, out_ready=1 -> in_ready falls in cycle 1; out_valid in cycle 33 with product=0x0000_0000_0000_000F; back in IDLE in cycle 34.
- op_a=0xFFFF_FFFF, op_b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001 (exercises the carry recovery on every iteration).
- op_a=0x8000_0000, op_b=0x0000_0002, with out_ready held low for 10 cycles after out_valid -> product=0x0000_0001_0000_0000 held stable for all 10 cycles; IDLE one cycle after out_ready rises.
- start pulsed in cycles 5 and 20 of an operation on 7x9 -> both pulses ignored; product=0x3F; exactly one out_valid window.
- Start 0x1234_5678 x 0x9ABC_DEF0, then assert abort in cycle 10 -> IDLE in cycle 11, no out_valid; an immediately following 2x2 yields product=4.
- rst asserted in cycle 15 of an operation -> in the next cycle in_ready=1, busy=0, out_valid=0, product=0; random regression of 1000 operand pairs matches a 64-bit reference multiply.
